// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-flags,
// sticky overflow/underflow errors and selectable FWFT read mode.
module sync_fifo_flags #(
  parameter int DATA_SIZE          = 8,
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int FWFT               = 0
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_reset,
  input  logic                 write_inc,
  input  logic [DATA_SIZE-1:0] write_data,
  input  logic                 read_inc,
  output logic [DATA_SIZE-1:0] read_data,
  input  logic                 error_clear,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_LEVEL = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0] AF_LEVEL   = ALMOST_FULL_LEVEL[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0] AE_LEVEL   = ALMOST_EMPTY_LEVEL[ADDR_SIZE:0];

  if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: ALMOST_FULL_LEVEL out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: ALMOST_EMPTY_LEVEL out of range 0..DEPTH-1");
  end

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE:0]   write_ptr;
  logic [ADDR_SIZE:0]   read_ptr;
  logic                 write_ok;
  logic                 read_ok;

  // Flags decode from registered pointers only, so they never follow the requests combinationally.
  assign level        = write_ptr - read_ptr;
  assign full         = (level == FULL_LEVEL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_LEVEL);
  assign almost_empty = (level <= AE_LEVEL);

  assign write_ok = write_inc && !full;
  assign read_ok  = read_inc && !empty;

  // NOTE: storage has no reset; only pointers and flags define validity, so the array maps to plain RAM.
  always_ff @(posedge fifo_clk) begin
    if (write_ok) mem[write_ptr[ADDR_SIZE-1:0]] <= write_data;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      write_ptr <= '0;
      read_ptr  <= '0;
    end else begin
      if (write_ok) write_ptr <= write_ptr + 1'b1;
      if (read_ok)  read_ptr  <= read_ptr + 1'b1;
    end
  end

  // A new error event takes priority over error_clear in the same cycle.
  always_ff @(posedge fifo_clk or posedge fifo_reset) begin
    if (fifo_reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_inc && full)     overflow <= 1'b1;
      else if (error_clear)      overflow <= 1'b0;
      if (read_inc && empty)     underflow <= 1'b1;
      else if (error_clear)      underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign read_data = mem[read_ptr[ADDR_SIZE-1:0]];
  end else begin : g_registered
    logic [DATA_SIZE-1:0] read_reg;

    always_ff @(posedge fifo_clk or posedge fifo_reset) begin
      if (fifo_reset)   read_reg <= '0;
      else if (read_ok) read_reg <= mem[read_ptr[ADDR_SIZE-1:0]];
    end

    assign read_data = read_reg;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: a registered-read instance driven against
// a reference model, plus a first-word-fall-through instance checked directly.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance
  logic       rst = 1'b1;
  logic       write_inc = 1'b0, read_inc = 1'b0, error_clear = 1'b0;
  logic [7:0] write_data = '0;
  logic [7:0] read_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  // FWFT instance
  logic       rst_f = 1'b1;
  logic       write_inc_f = 1'b0, read_inc_f = 1'b0, error_clear_f = 1'b0;
  logic [7:0] write_data_f = '0;
  logic [7:0] read_data_f;
  logic       full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [4:0] level_f;

  sync_fifo_flags dut (
    .fifo_clk(clk), .fifo_reset(rst), .write_inc(write_inc), .write_data(write_data),
    .read_inc(read_inc), .read_data(read_data), .error_clear(error_clear),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.FWFT(1)) dut_fwft (
    .fifo_clk(clk), .fifo_reset(rst_f), .write_inc(write_inc_f), .write_data(write_data_f),
    .read_inc(read_inc_f), .read_data(read_data_f), .error_clear(error_clear_f),
    .full(full_f), .empty(empty_f), .almost_full(almost_full_f), .almost_empty(almost_empty_f),
    .level(level_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0] sb[$];
  int         m_level = 0;
  bit         m_ov = 0, m_uf = 0;
  logic [7:0] m_rd = '0;

  task automatic check_all();
    check("level", level, m_level);
    check("full", full, m_level == 16);
    check("empty", empty, m_level == 0);
    check("almost_full", almost_full, m_level >= 12);
    check("almost_empty", almost_empty, m_level <= 2);
    check("overflow", overflow, m_ov);
    check("underflow", underflow, m_uf);
    check("read_data", read_data, m_rd);
  endtask

  // One clock of stimulus on the registered instance, then model update and compare.
  task automatic cycle(input bit w, input logic [7:0] wd, input bit r, input bit clr);
    bit w_ok, r_ok;
    write_inc = w; write_data = wd; read_inc = r; error_clear = clr;
    @(posedge clk);
    #1;
    w_ok = w && (m_level != 16);
    r_ok = r && (m_level != 0);
    if (w && m_level == 16) m_ov = 1; else if (clr) m_ov = 0;
    if (r && m_level == 0)  m_uf = 1; else if (clr) m_uf = 0;
    if (r_ok) m_rd = sb.pop_front();
    if (w_ok) sb.push_back(wd);
    m_level = m_level + int'(w_ok) - int'(r_ok);
    write_inc = 0; read_inc = 0; error_clear = 0;
    check_all();
  endtask

  initial begin
    int  widx;
    int  nw;
    bit  w, r;

    // Reset state, checked before any clock edge
    #1;
    check_all();
    check("fwft_reset_empty", empty_f, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    rst_f = 1'b0;
    #1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    check("fill_full", full, 1'b1);

    // Write while full, then clear
    cycle(1, 8'hAA, 0, 0);
    check("ovf_set", overflow, 1'b1);
    cycle(0, 8'h00, 0, 1);
    check("ovf_clear", overflow, 1'b0);

    // Drain in order, then one extra read
    for (int i = 0; i < 16; i++) begin
      cycle(0, 8'h00, 1, 0);
      check("drain_data", read_data, i);
    end
    cycle(0, 8'h00, 1, 0);
    check("udf_set", underflow, 1'b1);
    check("udf_hold", read_data, 8'h0F);
    cycle(0, 8'h00, 0, 1);

    // Wrap-around with level held in 5..9
    widx = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(1, widx[7:0], 0, 0);
      widx++;
    end
    nw = 0;
    for (int k = 0; k < 400 && nw < 40; k++) begin
      w = (m_level < 9) && ($urandom_range(0, 1) == 1);
      r = (m_level > 5) && ($urandom_range(0, 1) == 1);
      cycle(w, widx[7:0], r, 0);
      if (w) begin
        widx++;
        nw++;
      end
    end
    check("wrap_writes", nw, 40);

    // Simultaneous read/write at level 16
    while (m_level < 16) cycle(1, 8'h33, 0, 0);
    cycle(1, 8'hBB, 1, 0);
    check("rw_full_level", level, 15);
    check("rw_full_ovf", overflow, 1'b1);

    // At level 0, together with error_clear: underflow set wins, overflow clears
    while (m_level > 0) cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hCC, 1, 1);
    check("rw_empty_level", level, 1);
    check("rw_empty_udf", underflow, 1'b1);
    check("rw_empty_ovf", overflow, 1'b0);

    // At level 8, no error flags
    cycle(0, 8'h00, 0, 1);
    while (m_level < 8) cycle(1, 8'h44, 0, 0);
    cycle(1, 8'h55, 1, 0);
    check("rw_mid_level", level, 8);
    check("rw_mid_ovf", overflow, 1'b0);
    check("rw_mid_udf", underflow, 1'b0);

    // FWFT instance: word visible before any read
    write_inc_f = 1; write_data_f = 8'h5A;
    @(posedge clk);
    #1;
    write_inc_f = 0;
    check("fwft_not_empty", empty_f, 1'b0);
    check("fwft_show", read_data_f, 8'h5A);
    for (int i = 1; i < 7; i++) begin
      write_inc_f = 1; write_data_f = 8'(i);
      @(posedge clk);
      #1;
    end
    write_inc_f = 0;
    check("fwft_level7", level_f, 7);
    check("fwft_head", read_data_f, 8'h5A);
    read_inc_f = 1;
    @(posedge clk);
    #1;
    read_inc_f = 0;
    check("fwft_pop", read_data_f, 8'h01);
    check("fwft_level6", level_f, 6);
    write_inc_f = 1; write_data_f = 8'h07;
    @(posedge clk);
    #1;
    write_inc_f = 0;
    check("fwft_refill", level_f, 7);

    // Asynchronous reset mid-stream
    #2;
    rst_f = 1'b1;
    #1;
    check("fwft_rst_level", level_f, 0);
    check("fwft_rst_empty", empty_f, 1'b1);
    check("fwft_rst_ae", almost_empty_f, 1'b1);
    @(negedge clk);
    rst_f = 1'b0;
    @(posedge clk);
    #1;
    check("fwft_post_rst_empty", empty_f, 1'b1);
    check("fwft_post_rst_level", level_f, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
